// File: rtl/spi_ram_port.sv
// Command-decoding single-port RAM behind the SPI slave: 2-bit opcode plus 8-bit payload per word.
// Define SPI_RAM_ADDR_AUTO_INC_EN to post-increment the address after each accepted data command.
module spi_ram_port #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       cmd_err
);

  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;
  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_t;

  logic [7:0]           mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr, rd_ptr, addr_field;
  logic                 wr_addr_vld, rd_addr_vld;
  logic                 wr_fire, rd_fire;
  rd_state_t            rd_state;
  cmd_t                 cmd;

  assign cmd        = cmd_t'(rx_data[9:8]);
  assign addr_field = rx_data[ADDR_SIZE-1:0];
  assign wr_fire    = rst && rx_valid && (cmd == WR_DATA) && wr_addr_vld;
  assign rd_fire    = rst && rx_valid && (cmd == RD_DATA) && rd_addr_vld;

  // Storage has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_addr] <= rx_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      cmd_err     <= 1'b0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      rd_ptr      <= '0;
      wr_addr_vld <= 1'b0;
      rd_addr_vld <= 1'b0;
      rd_state    <= RD_IDLE;
    end else begin
      tx_valid <= 1'b0;
      cmd_err  <= 1'b0;
      if (rd_state == RD_RESP) begin
        tx_data  <= mem[rd_ptr];
        tx_valid <= 1'b1;
      end
      // rd_ptr freezes the pre-increment address for the response cycle.
      rd_state <= rd_fire ? RD_RESP : RD_IDLE;
      if (rd_fire) rd_ptr <= rd_addr;
      if (rx_valid) begin
        case (cmd)
          WR_ADDR: begin
            wr_addr     <= addr_field;
            wr_addr_vld <= 1'b1;
          end
          WR_DATA: begin
            if (!wr_addr_vld) cmd_err <= 1'b1;
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
            else wr_addr <= wr_addr + ADDR_SIZE'(1);
`endif
          end
          RD_ADDR: begin
            rd_addr     <= addr_field;
            rd_addr_vld <= 1'b1;
          end
          RD_DATA: begin
            if (!rd_addr_vld) cmd_err <= 1'b1;
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
            else rd_addr <= rd_addr + ADDR_SIZE'(1);
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule
